rsa_xcel_modexp_arbiter: RTL and testbench
==========================================

// Module: rsa_xcel_modexp_arbiter
//
// PURPOSE
//  Shares one modular-exponentiation unit between NREQS stream requesters (e.g. several xcel adapters).
//  Grants round-robin, buffers the winning {mod,exp,base} request, sequences one modexp transaction,
//  and returns the 32-bit result only to the granted requester. Sits between the adapters and modexp.
//
// PARAMETERS
//  NREQS   2   number of requesters, >=1; lane i uses bits [i*W +: W] of each flattened bus
//  OWNW    $clog2(NREQS) (min 1)   width of the owner index
//
// PORTS
//  clk                 in   1         clock; all state updates on posedge
//  reset               in   1         asynchronous, active-high reset
//  req_istream_msg     in   NREQS*96  per-lane request: [95:64] mod, [63:32] exp, [31:0] base
//  req_istream_val     in   NREQS     per-lane request valid
//  req_istream_rdy     out  NREQS     per-lane request accept (one-hot or zero)
//  req_ostream_msg     out  NREQS*32  per-lane result
//  req_ostream_val     out  NREQS     per-lane result valid (one-hot or zero)
//  req_ostream_rdy     in   NREQS     per-lane result ready
//  modexp_istream_msg  out  96        request to modexp, same packing
//  modexp_istream_val  out  1
//  modexp_istream_rdy  in   1
//  modexp_ostream_msg  in   32        modexp result
//  modexp_ostream_val  in   1
//  modexp_ostream_rdy  out  1
//  busy                out  1         1 in any state other than IDLE
//  owner               out  OWNW      index of current/last granted lane
//
// BEHAVIOUR
//  - Reset (async): state=IDLE, ptr=0, owner=0, req_reg=0, res_reg=0. While reset high all rdy/val
//    outputs are 0 (req_istream_rdy gated by !reset); all msg outputs 0.
//  - Streams are val/rdy: transfer when both high in same cycle; requesters hold val+msg until rdy.
//  - FSM states IDLE, SEND, WAIT, RESP:
//    IDLE: winner g = first lane with val=1 scanning ptr, ptr+1, ... mod NREQS (wrap). req_istream_rdy[g]=1
//          (combinational, this cycle only); next edge: req_reg<=msg[g], owner<=g, ->SEND. No val: stay.
//    SEND: modexp_istream_val=1, msg=req_reg; on modexp_istream_rdy ->WAIT.
//    WAIT: modexp_ostream_rdy=1; on modexp_ostream_val: res_reg<=modexp_ostream_msg, ->RESP.
//    RESP: req_ostream_val[owner]=1, req_ostream_msg lane owner=res_reg; on req_ostream_rdy[owner]:
//          ptr<=(owner+1) mod NREQS, ->IDLE.
//  - Min latency accept->result valid: 3 cycles with zero-latency modexp (IDLE,SEND,WAIT edges).
//  - One transaction in flight; all other lanes rdy=0 outside IDLE; new grant earliest cycle after RESP.
//  - Non-owner lanes and idle outputs drive msg=0 (4-state hygiene); modexp_istream_msg=0 outside SEND.
//  - Simultaneous val on all lanes: strictly rotating grants, no lane starved beyond NREQS-1 grants.
//  - ptr wraps NREQS-1 -> 0; NREQS=1 degenerates to pass-through sequencer (ptr stays 0).
//  - Reset mid-transaction aborts it; no result delivered; modexp shares reset and is assumed cleared.
//  - modexp_ostream_val outside WAIT is ignored (rdy=0), never captured.
//
// TESTING
//  1. Lane0 {mod=497,exp=13,base=4} alone -> lane0 result 445, lane1 ostream_val never high.
//  2. Lanes 0,1 val same cycle after reset: {7,4,3} and {1000,10,2} -> lane0 gets 4 first, then lane1 24.
//  3. Back-to-back saturation, NREQS=3, all lanes always valid -> grant order 0,1,2,0,1,2; owner matches.
//  4. Lane1 holds req_ostream_rdy=0 for 5 cycles -> val/msg held stable, no new grant, busy=1 throughout.
//  5. Assert reset during WAIT -> all val/rdy 0 immediately, state IDLE, ptr=0, no stale result later.
//  6. modexp_istream_rdy low 4 cycles in SEND -> modexp_istream_msg stable, req_istream_rdy all 0.

Source files
------------

// File: rtl/rsa_xcel_modexp_arbiter.sv
// rsa_xcel_modexp_arbiter: round-robin share of one modexp unit among NREQS val/rdy requesters,
// one transaction in flight, result routed back only to the granted lane.
module rsa_xcel_modexp_arbiter #(
    parameter int NREQS = 2,
    parameter int OWNW  = (NREQS > 1) ? $clog2(NREQS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQS*96-1:0]   req_istream_msg,
    input  logic [NREQS-1:0]      req_istream_val,
    output logic [NREQS-1:0]      req_istream_rdy,
    output logic [NREQS*32-1:0]   req_ostream_msg,
    output logic [NREQS-1:0]      req_ostream_val,
    input  logic [NREQS-1:0]      req_ostream_rdy,
    output logic [95:0]           modexp_istream_msg,
    output logic                  modexp_istream_val,
    input  logic                  modexp_istream_rdy,
    input  logic [31:0]           modexp_ostream_msg,
    input  logic                  modexp_ostream_val,
    output logic                  modexp_ostream_rdy,
    output logic                  busy,
    output logic [OWNW-1:0]       owner
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [OWNW-1:0] ptr_q, ptr_d, owner_q, owner_d;
    logic [95:0]     req_q, req_d;
    logic [31:0]     res_q, res_d;
    logic            gnt_val;
    logic [OWNW-1:0] gnt_idx;
    logic [NREQS-1:0] gnt_oh, own_oh;
    logic [95:0]     gnt_msg;

    // Winner is the valid lane with the smallest rotational distance from ptr.
    always_comb begin
        int d, best;
        d = 0;
        best = NREQS;
        gnt_val = 1'b0;
        gnt_idx = '0;
        gnt_oh = '0;
        gnt_msg = '0;
        for (int i = 0; i < NREQS; i++) begin
            d = i - int'(ptr_q);
            if (d < 0) d = d + NREQS;
            if (req_istream_val[i] && d < best) begin
                best = d;
                gnt_val = 1'b1;
                gnt_idx = OWNW'(i);
                gnt_oh = '0;
                gnt_oh[i] = 1'b1;
                gnt_msg = req_istream_msg[i*96 +: 96];
            end
        end
    end

    always_comb begin
        own_oh = '0;
        for (int i = 0; i < NREQS; i++) own_oh[i] = (OWNW'(i) == owner_q);
    end

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        owner_d = owner_q;
        req_d = req_q;
        res_d = res_q;
        case (state_q)
            IDLE: if (gnt_val) begin
                req_d = gnt_msg;
                owner_d = gnt_idx;
                state_d = SEND;
            end
            SEND: if (modexp_istream_rdy) state_d = WAIT;
            WAIT: if (modexp_ostream_val) begin
                res_d = modexp_ostream_msg;
                state_d = RESP;
            end
            RESP: if (|(req_ostream_rdy & own_oh)) begin
                ptr_d = (int'(owner_q) == NREQS - 1) ? '0 : owner_q + OWNW'(1);
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            owner_q <= '0;
            req_q <= '0;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            req_q <= req_d;
            res_q <= res_d;
        end
    end

    // Reset gating keeps a requester from seeing an accept that the held-in-reset FSM never takes.
    assign req_istream_rdy    = (!reset && state_q == IDLE) ? gnt_oh : '0;
    assign req_ostream_val    = (state_q == RESP) ? own_oh : '0;
    assign modexp_istream_val = (state_q == SEND);
    assign modexp_istream_msg = (state_q == SEND) ? req_q : '0;
    assign modexp_ostream_rdy = (state_q == WAIT);
    assign busy               = (state_q != IDLE);
    assign owner              = owner_q;

    always_comb begin
        req_ostream_msg = '0;
        for (int i = 0; i < NREQS; i++)
            req_ostream_msg[i*32 +: 32] = (state_q == RESP && own_oh[i]) ? res_q : 32'd0;
    end
endmodule

// File: tb/tb_rsa_xcel_modexp_arbiter.sv
// tb_rsa_xcel_modexp_arbiter: directed checks of the modexp arbiter with three lanes and a
// behavioural modexp responder that can stall, hold its result or emit spurious valids.
module tb_rsa_xcel_modexp_arbiter;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*96-1:0] imsg = '0;
    logic [N-1:0]    ival = '0;
    logic [N-1:0]    irdy;
    logic [N*32-1:0] omsg;
    logic [N-1:0]    oval;
    logic [N-1:0]    ordy = '1;
    logic [95:0]     mx_imsg;
    logic            mx_ival, mx_irdy, mx_oval, mx_ordy;
    logic [31:0]     mx_omsg;
    logic            busy;
    logic [1:0]      owner;

    logic            mx_stall = 1'b0, mx_hold = 1'b0, mx_spur = 1'b0, mx_pend;
    logic [31:0]     mx_res;
    logic            sat = 1'b0;
    int              checks = 0, errors = 0, oh_err = 0;
    int              grants[$], owners[$], dlane[$];
    logic [31:0]     dres[$];

    always #5 clk = ~clk;

    rsa_xcel_modexp_arbiter #(.NREQS(N)) dut (
        .clk(clk), .reset(reset),
        .req_istream_msg(imsg), .req_istream_val(ival), .req_istream_rdy(irdy),
        .req_ostream_msg(omsg), .req_ostream_val(oval), .req_ostream_rdy(ordy),
        .modexp_istream_msg(mx_imsg), .modexp_istream_val(mx_ival), .modexp_istream_rdy(mx_irdy),
        .modexp_ostream_msg(mx_omsg), .modexp_ostream_val(mx_oval), .modexp_ostream_rdy(mx_ordy),
        .busy(busy), .owner(owner)
    );

    function automatic logic [31:0] mexp(logic [95:0] m);
        logic [63:0] md, r, b;
        logic [31:0] e;
        md = {32'd0, m[95:64]};
        e = m[63:32];
        b = {32'd0, m[31:0]} % md;
        r = 64'd1 % md;
        while (e != 0) begin
            if (e[0]) r = (r * b) % md;
            b = (b * b) % md;
            e = e >> 1;
        end
        return r[31:0];
    endfunction

    assign mx_irdy = !mx_stall && !mx_pend;
    assign mx_oval = (mx_pend && !mx_hold) || mx_spur;
    assign mx_omsg = mx_pend ? mx_res : 32'hDEAD_BEEF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mx_pend <= 1'b0;
        else if (mx_ival && mx_irdy) begin
            mx_pend <= 1'b1;
            mx_res <= mexp(mx_imsg);
        end else if (mx_oval && mx_ordy) mx_pend <= 1'b0;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setreq(input int l, input logic [95:0] m);
        imsg[l*96 +: 96] = m;
        ival[l] = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = ival & irdy;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) grants.push_back(i);
            if (oval[i] && ordy[i]) begin
                dlane.push_back(i);
                dres.push_back(omsg[i*32 +: 32]);
            end
        end
        if ($countones(oval) > 1 || $countones(irdy) > 1) oh_err++;
        @(posedge clk);
        #1;
        if (acc != 0) owners.push_back(int'(owner));
        if (!sat) ival = ival & ~acc;
        #1;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && dlane.size() < n; c++) tick();
        check("deliveries", dlane.size(), n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ival = '0;
        sat = 1'b0;
        mx_stall = 1'b0;
        mx_hold = 1'b0;
        mx_spur = 1'b0;
        ordy = '1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        grants.delete();
        owners.delete();
        dlane.delete();
        dres.delete();
        #1;
    endtask

    initial begin
        // Reset state, with every lane requesting so the rdy gating is exercised.
        ival = '1;
        #3;
        check("rst_irdy", irdy, 0);
        check("rst_oval", oval, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_mxval", mx_ival, 0);
        check("rst_mxmsg", mx_imsg, 0);
        check("rst_mxordy", mx_ordy, 0);
        do_reset();

        // 1: lane0 alone, 3-cycle latency to result valid.
        setreq(0, {32'd497, 32'd13, 32'd4});
        #1;
        check("t1_irdy", irdy, 3'b001);
        tick();
        check("t1_send_busy", busy, 1);
        check("t1_send_val", mx_ival, 1);
        check("t1_send_msg", mx_imsg, {32'd497, 32'd13, 32'd4});
        check("t1_send_irdy", irdy, 0);
        tick();
        check("t1_wait_ordy", mx_ordy, 1);
        tick();
        check("t1_resp_val", oval, 3'b001);
        check("t1_resp_msg", omsg[31:0], 445);
        tick();
        check("t1_dcount", dlane.size(), 1);
        check("t1_dlane", dlane[0], 0);
        check("t1_dres", dres[0], 445);
        check("t1_idle", busy, 0);

        // 2: lanes 0 and 1 together after reset, lane0 first.
        do_reset();
        setreq(0, {32'd7, 32'd4, 32'd3});
        setreq(1, {32'd1000, 32'd10, 32'd2});
        run_until(2, 40);
        check("t2_lane_a", dlane[0], 0);
        check("t2_res_a", dres[0], 4);
        check("t2_lane_b", dlane[1], 1);
        check("t2_res_b", dres[1], 24);

        // 3: all lanes always valid, strict rotation.
        do_reset();
        sat = 1'b1;
        for (int i = 0; i < N; i++) setreq(i, {32'd11, 32'd2, 32'(i + 2)});
        for (int c = 0; c < 100 && grants.size() < 6; c++) tick();
        sat = 1'b0;
        ival = '0;
        run_until(6, 40);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_grant%0d", k), grants[k], k % 3);
            check($sformatf("t3_owner%0d", k), owners[k], k % 3);
            check($sformatf("t3_res%0d", k), dres[k], (k % 3 == 0) ? 4 : (k % 3 == 1) ? 9 : 5);
        end

        // 4: lane1 backpressures its result for 5 cycles.
        do_reset();
        ordy[1] = 1'b0;
        setreq(1, {32'd1000, 32'd10, 32'd2});
        repeat (3) tick();
        setreq(0, {32'd7, 32'd4, 32'd3});
        #1;
        for (int c = 0; c < 5; c++) begin
            check("t4_oval", oval, 3'b010);
            check("t4_omsg", omsg[63:32], 24);
            check("t4_busy", busy, 1);
            check("t4_irdy", irdy, 0);
            tick();
        end
        ordy[1] = 1'b1;
        #1;
        tick();
        check("t4_dres", dres[0], 24);
        check("t4_next_irdy", irdy, 3'b001);
        run_until(2, 20);
        check("t4_dres2", dres[1], 4);

        // 5: reset during WAIT aborts the transaction and clears ptr.
        do_reset();
        setreq(0, {32'd7, 32'd4, 32'd3});
        run_until(1, 20);
        mx_hold = 1'b1;
        setreq(2, {32'd1000, 32'd10, 32'd2});
        #1;
        check("t5_irdy_ptr1", irdy, 3'b100);
        tick();
        tick();
        check("t5_wait_ordy", mx_ordy, 1);
        ival = '1;
        reset = 1'b1;
        #1;
        check("t5_rst_irdy", irdy, 0);
        check("t5_rst_oval", oval, 0);
        check("t5_rst_mxval", mx_ival, 0);
        check("t5_rst_mxordy", mx_ordy, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_owner", owner, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mx_hold = 1'b0;
        ival = 3'b011;
        #1;
        check("t5_ptr0", irdy, 3'b001);
        ival = '0;
        #1;
        repeat (8) tick();
        check("t5_no_stale", dlane.size(), 1);

        // 6: modexp input stalls in SEND while another lane and a spurious result wait.
        do_reset();
        mx_stall = 1'b1;
        setreq(0, {32'd497, 32'd13, 32'd4});
        tick();
        setreq(1, {32'd7, 32'd4, 32'd3});
        mx_spur = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("t6_mxmsg", mx_imsg, {32'd497, 32'd13, 32'd4});
            check("t6_mxval", mx_ival, 1);
            check("t6_irdy", irdy, 0);
            check("t6_mxordy", mx_ordy, 0);
            tick();
        end
        mx_stall = 1'b0;
        mx_spur = 1'b0;
        run_until(2, 40);
        check("t6_lane_a", dlane[0], 0);
        check("t6_res_a", dres[0], 445);
        check("t6_lane_b", dlane[1], 1);
        check("t6_res_b", dres[1], 4);

        check("onehot", oh_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
